cp0_irq_ctrl: RTL and testbench
===============================

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4, number of external interrupt lines (legal range 1..8).
REQ-002 Parameter VECTORED, default 0, 0 = single handler address, 1 = per-line vector.
REQ-003 Parameter VEC_STRIDE, default 32'h20, byte spacing between vectors when VECTORED=1.
REQ-004 Parameter EBASE_RST, default 32'h0000_0080, reset value of the handler base register.
REQ-005 Ports: clk, in, 1, clock. The block SHALL use clk as its clock.
REQ-006 Ports: rst, in, 1. The block SHALL use rst as its reset: synchronous, active-high.
REQ-007 oper  in  2  CP0 operation: 00 read, 01 store, 10 ERET, 11 no-op.
REQ-008 addr_r  in  5  read register index (ID stage).
REQ-009 data_r  out  32  registered read data.
REQ-010 addr_w  in  5  write register index (EXE stage).
REQ-011 data_w  in  32  write data.
REQ-012 ir_en  in  1  pipeline permits interrupt this cycle (MEM stage valid).
REQ-013 ir_in  in  NUM_IRQ  external interrupt request lines, level inputs.
REQ-014 ret_addr  in  32  address saved to EPC when an interrupt is taken.
REQ-015 jump_en  out  1  force-jump request to the PC unit.
REQ-016 jump_addr  out  32  force-jump target.

Function
REQ-017 Registers: STATUS=12 (bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM), CAUSE=13 (bits[8+NUM_IRQ-1:8] IP, bits[6:2] code), EPC=14, EBASE=15, all others generic 32-bit storage; unimplemented STATUS/CAUSE bits SHALL read 0.
REQ-018 oper=00: data_r SHALL load the register at addr_r on the next clk edge; other opers hold data_r.
REQ-019 oper=01: register addr_w SHALL take data_w at the next edge, except CAUSE, where writing 1 to an IP bit clears it and the other CAUSE bits are read-only.
REQ-020 IP[i] SHALL be set on the edge after a 0->1 transition of ir_in[i] (one-cycle edge detector) and stay set until software clears it; set wins over a same-cycle clear.
REQ-021 take = ir_en & IE & ~EXL & |(IP & IM), evaluated combinationally.
REQ-022 Winner SHALL be the lowest set index of IP & IM.
REQ-023 When take=1, in the same cycle: jump_en=1, jump_addr = EBASE if VECTORED=0, else EBASE + winner*VEC_STRIDE (32-bit, wrap-around).
REQ-024 At the edge ending a take cycle: EPC<=ret_addr, EXL<=1, CAUSE.code<=winner index.
REQ-025 oper=10 SHALL set an internal eret flag for exactly one cycle following the edge; during that cycle jump_en=1, jump_addr=EPC, and EXL clears at the end of that cycle.
REQ-026 In an eret cycle, take SHALL be suppressed even if its conditions hold (EXL is still 1), so a pending interrupt is taken no earlier than the following cycle.
REQ-027 A software store to STATUS or EPC in the same edge as a take update SHALL lose to the take update for EXL and EPC; other STATUS bits take data_w.
REQ-028 jump_en SHALL be 0 in every cycle that is neither a take cycle nor an eret cycle; jump_addr is don't-care when jump_en=0 but SHALL be driven (no latches).
REQ-029 Re-entry SHALL be prevented solely by EXL; new edges while EXL=1 set IP and are serviced after ERET.

Reset
REQ-030 rst SHALL, at the clk edge, clear STATUS, CAUSE, EPC, eret flag, edge-detector history, data_r, and generic registers to 0, and load EBASE=EBASE_RST.
REQ-031 rst SHALL take priority over every oper and interrupt event in that cycle; jump_en SHALL be 0 while rst=1.

Verification
REQ-032 Reset, store STATUS=32'h0000_0101, pulse ir_in[0], ir_en=1, ret_addr=32'h100 -> jump_en=1, jump_addr=32'h80 one cycle after the edge; EPC reads 32'h100, code=0, EXL=1.
REQ-033 VECTORED=1, IM=4'b1111, IE=1, raise ir_in[3] and ir_in[2] same cycle -> jump_addr=32'hC0 (line 2); after ERET and W1C of IP[2], line 3 taken at 32'hE0.
REQ-034 In handler (EXL=1), pulse ir_in[1] -> no jump_en; issue ERET -> eret cycle jump_addr=EPC, next cycle jump_en=1 to the line-1 vector.
REQ-035 IM[0]=0, pulse ir_in[0] -> IP[0] reads 1, no jump; set IM[0]=1 -> take on the next cycle with ir_en=1; with ir_en=0 the take is held off.
REQ-036 Assert rst during a take cycle -> jump_en=0, STATUS/CAUSE/EPC read 0, EBASE reads EBASE_RST.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
// rtl/cp0_irq_ctrl.sv - CP0 register file with edge-triggered interrupt capture, priority select and ERET
module cp0_irq_ctrl #(
    parameter int          NUM_IRQ    = 4,
    parameter int          VECTORED   = 0,
    parameter logic [31:0] VEC_STRIDE = 32'h20,
    parameter logic [31:0] EBASE_RST  = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         oper,
    input  logic [4:0]         addr_r,
    output logic [31:0]        data_r,
    input  logic [4:0]         addr_w,
    input  logic [31:0]        data_w,
    input  logic               ir_en,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic [31:0]        ret_addr,
    output logic               jump_en,
    output logic [31:0]        jump_addr
);
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] REG_EBASE  = 5'd15;
    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_STORE   = 2'b01;
    localparam logic [1:0] OP_ERET    = 2'b10;

    logic               ie;
    logic               exl;
    logic               eret;
    logic [NUM_IRQ-1:0] im;
    logic [NUM_IRQ-1:0] ip;
    logic [NUM_IRQ-1:0] ir_prev;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] ip_clr;
    logic [NUM_IRQ-1:0] ip_next;
    logic [4:0]         code;
    logic [31:0]        epc;
    logic [31:0]        ebase;
    logic [31:0][31:0]  gen_reg;
    logic [2:0]         winner;
    logic               take;
    logic               store;
    logic [31:0]        status_val;
    logic [31:0]        cause_val;
    logic [31:0]        rd_val;

    assign store = (oper == OP_STORE);
    assign pend  = ip & im;

    // Scan from the top down so the lowest pending index is the last assignment.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) winner = 3'(i);
        end
    end

    // The eret cycle still has EXL set; gating on eret makes the suppression explicit.
    assign take    = ~rst & ~eret & ir_en & ie & ~exl & (|pend);
    assign jump_en = ~rst & (take | eret);

    always_comb begin
        if (eret)
            jump_addr = epc;
        else if (VECTORED != 0)
            jump_addr = ebase + 32'(winner) * VEC_STRIDE;
        else
            jump_addr = ebase;
    end

    always_comb begin
        status_val                = '0;
        status_val[0]             = ie;
        status_val[1]             = exl;
        status_val[8 +: NUM_IRQ]  = im;
        cause_val                 = '0;
        cause_val[8 +: NUM_IRQ]   = ip;
        cause_val[6:2]            = code;
        case (addr_r)
            REG_STATUS: rd_val = status_val;
            REG_CAUSE:  rd_val = cause_val;
            REG_EPC:    rd_val = epc;
            REG_EBASE:  rd_val = ebase;
            default:    rd_val = gen_reg[addr_r];
        endcase
    end

    // New edges are OR-ed in after the write-one-to-clear so a same-cycle set wins.
    assign ip_clr  = (store && addr_w == REG_CAUSE) ? data_w[8 +: NUM_IRQ] : '0;
    assign ip_next = (ip & ~ip_clr) | (ir_in & ~ir_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            ie      <= 1'b0;
            exl     <= 1'b0;
            im      <= '0;
            ip      <= '0;
            code    <= '0;
            epc     <= '0;
            ebase   <= EBASE_RST;
            eret    <= 1'b0;
            ir_prev <= '0;
            data_r  <= '0;
            gen_reg <= '0;
        end else begin
            ir_prev <= ir_in;
            eret    <= (oper == OP_ERET);
            ip      <= ip_next;
            if (oper == OP_READ) data_r <= rd_val;
            if (store) begin
                gen_reg[addr_w] <= data_w;
                if (addr_w == REG_STATUS) begin
                    ie  <= data_w[0];
                    exl <= data_w[1];
                    im  <= data_w[8 +: NUM_IRQ];
                end
                if (addr_w == REG_EPC)   epc   <= data_w;
                if (addr_w == REG_EBASE) ebase <= data_w;
            end
            // Later assignments override the software store for EXL and EPC.
            if (take) begin
                epc  <= ret_addr;
                exl  <= 1'b1;
                code <= {2'b00, winner};
            end
            if (eret) exl <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb/tb_cp0_irq_ctrl.sv - directed and randomized checks of cp0_irq_ctrl against a behavioural model
module tb_cp0_irq_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   oper = 2'b11;
    logic [4:0]   addr_r = '0;
    logic [4:0]   addr_w = '0;
    logic [31:0]  data_w = '0;
    logic         ir_en = 1'b0;
    logic [N-1:0] ir_in = '0;
    logic [31:0]  ret_addr = '0;
    logic [31:0]  data_r;
    logic         jump_en;
    logic [31:0]  jump_addr;

    always #5 clk = ~clk;

    cp0_irq_ctrl #(
        .NUM_IRQ(N), .VECTORED(1), .VEC_STRIDE(32'h20), .EBASE_RST(32'h80)
    ) dut (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Behavioural model: architectural state as plain variables.
    bit          m_ie, m_exl, m_eret;
    bit [N-1:0]  m_im, m_ip, m_prev;
    int          m_code;
    logic [31:0] m_epc, m_ebase, m_data_r;
    logic [31:0] m_gen [32];

    function automatic int m_winner();
        for (int i = 0; i < N; i++)
            if (m_ip[i] && m_im[i]) return i;
        return 0;
    endfunction

    function automatic bit m_take();
        return !rst && !m_eret && ir_en && m_ie && !m_exl && ((m_ip & m_im) != 0);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        case (a)
            12: return 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im) << 8);
            13: return (32'(m_ip) << 8) | (32'(m_code) << 2);
            14: return m_epc;
            15: return m_ebase;
            default: return m_gen[a];
        endcase
    endfunction

    task automatic m_reset();
        m_ie = 0; m_exl = 0; m_eret = 0; m_im = '0; m_ip = '0; m_prev = '0;
        m_code = 0; m_epc = '0; m_ebase = 32'h80; m_data_r = '0;
        for (int i = 0; i < 32; i++) m_gen[i] = '0;
    endtask

    task automatic m_step();
        bit tk, old_eret;
        int w;
        if (rst) begin
            m_reset();
            return;
        end
        tk = m_take(); w = m_winner(); old_eret = m_eret;
        if (oper == 2'b00) m_data_r = m_read(int'(addr_r));
        if (oper == 2'b01) begin
            case (int'(addr_w))
                12: begin m_ie = data_w[0]; m_exl = data_w[1]; m_im = data_w[8 +: N]; end
                13: m_ip = m_ip & ~data_w[8 +: N];
                14: m_epc = data_w;
                15: m_ebase = data_w;
                default: m_gen[addr_w] = data_w;
            endcase
        end
        m_ip = m_ip | (ir_in & ~m_prev);
        if (tk) begin m_epc = ret_addr; m_exl = 1; m_code = w; end
        if (old_eret) m_exl = 0;
        m_eret = (oper == 2'b10);
        m_prev = ir_in;
    endtask

    logic        obs_jen;
    logic [31:0] obs_jaddr;

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit exp_jen;
        logic [31:0] exp_addr;
        @(negedge clk);
        exp_jen  = !rst && (m_take() || m_eret);
        exp_addr = m_eret ? m_epc : m_ebase + 32'(m_winner()) * 32'h20;
        obs_jen   = jump_en;
        obs_jaddr = jump_addr;
        check("jump_en", 32'(jump_en), 32'(exp_jen));
        if (exp_jen) check("jump_addr", jump_addr, exp_addr);
        check("data_r", data_r, m_data_r);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic store(input logic [4:0] a, input logic [31:0] d);
        oper = 2'b01; addr_w = a; data_w = d;
        cycle();
        oper = 2'b11;
    endtask

    task automatic rd(input logic [4:0] a);
        oper = 2'b00; addr_r = a;
        cycle();
        oper = 2'b11;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        rst = 1'b0;
        cycle();
        check("rst_jen", 32'(obs_jen), 32'h0);
        rd(5'd15);
        check("rst_ebase", data_r, 32'h80);

        // Single-line take, vector 0
        ir_en = 1'b1; ret_addr = 32'h100;
        store(5'd12, 32'h101);
        ir_in = 4'b0001; cycle();
        ir_in = 4'b0000; cycle();
        check("t1_jen", 32'(obs_jen), 32'h1);
        check("t1_addr", obs_jaddr, 32'h80);
        rd(5'd14);
        check("t1_epc", data_r, 32'h100);
        rd(5'd12);
        check("t1_status", data_r, 32'h103);
        rd(5'd13);
        check("t1_cause", data_r, 32'h100);

        // Two lines at once: lowest index first, the other after ERET
        do_reset();
        ret_addr = 32'h200;
        store(5'd12, 32'hF01);
        ir_in = 4'b1100; cycle();
        cycle();
        check("t2_jen", 32'(obs_jen), 32'h1);
        check("t2_addr", obs_jaddr, 32'hC0);
        store(5'd13, 32'h400);
        oper = 2'b10; cycle(); oper = 2'b11;
        cycle();
        check("t2_eret_addr", obs_jaddr, 32'h200);
        cycle();
        check("t2_line3_jen", 32'(obs_jen), 32'h1);
        check("t2_line3_addr", obs_jaddr, 32'hE0);

        // New edge inside handler is held until after ERET
        store(5'd13, 32'h800);
        ir_in = 4'b1110; cycle();
        oper = 2'b10; cycle(); oper = 2'b11;
        check("t3_hold", 32'(obs_jen), 32'h0);
        cycle();
        check("t3_eret_jen", 32'(obs_jen), 32'h1);
        check("t3_eret_addr", obs_jaddr, 32'h200);
        cycle();
        check("t3_line1_addr", obs_jaddr, 32'hA0);

        // Masked line: pending but not taken; unmasking with ir_en low holds off
        ir_in = 4'b0000;
        do_reset();
        store(5'd12, 32'hE01);
        ir_in = 4'b0001; cycle();
        ir_in = 4'b0000; cycle();
        check("t4_masked", 32'(obs_jen), 32'h0);
        rd(5'd13);
        check("t4_ip0", data_r, 32'h100);
        ir_en = 1'b0;
        store(5'd12, 32'hF01);
        cycle();
        check("t4_ir_en_low", 32'(obs_jen), 32'h0);
        ir_en = 1'b1; cycle();
        check("t4_take", 32'(obs_jen), 32'h1);
        check("t4_addr", obs_jaddr, 32'h80);

        // Reset asserted in a take cycle
        store(5'd12, 32'hF01);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("t5_rst_jen", 32'(obs_jen), 32'h0);
        rd(5'd12); check("t5_status", data_r, 32'h0);
        rd(5'd13); check("t5_cause", data_r, 32'h0);
        rd(5'd14); check("t5_epc", data_r, 32'h0);
        rd(5'd15); check("t5_ebase", data_r, 32'h80);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            int r;
            rst = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) ir_in[b] = ~ir_in[b];
            ir_en    = ($urandom_range(0, 3) != 0);
            ret_addr = $urandom;
            r = $urandom_range(0, 19);
            if (r < 10) begin
                oper   = 2'b00;
                addr_r = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 15)) : 5'($urandom);
            end else if (r < 14) begin
                oper   = 2'b01;
                addr_w = ($urandom_range(0, 2) != 0) ? 5'($urandom_range(12, 15)) : 5'($urandom);
                data_w = $urandom;
                if (addr_w == 5'd12)
                    data_w = (data_w & 32'hFFFF_FFFC) | {30'b0, ($urandom_range(0, 3) == 0), 1'b1};
            end else if (r == 14) begin
                oper = 2'b10;
            end else begin
                oper = 2'b11;
            end
            cycle();
        end
        rst = 1'b0; oper = 2'b11;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
